// File: rtl/he_poly_pkg.sv
// Shared types for the polynomial datapath: FSM state encoding and the
// default coefficient type.
package he_poly_pkg;

  localparam int unsigned CoeffWidth = 8;

  typedef logic [CoeffWidth-1:0] coeff_t;

  typedef enum logic {
    StIdle,
    StEmit
  } state_e;

endpackage

// File: rtl/negacyclic_reducer.sv
// Folds a linear-convolution column vector modulo x^N + 1 in one cycle, then
// streams the N reduced coefficients out one per accepted output beat.
module negacyclic_reducer
  import he_poly_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned COEFF_WIDTH = CoeffWidth
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [2*N-2:0][COEFF_WIDTH-1:0]     in_cols,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [COEFF_WIDTH-1:0]              out_coeff,
  output logic [$clog2(N)-1:0]                out_index,
  output logic                                out_last
);

  localparam int unsigned IdxW = $clog2(N);

  state_e                         state_q, state_d;
  logic [IdxW-1:0]                idx_q, idx_d;
  logic [N-1:0][COEFF_WIDTH-1:0]  coeff_q, coeff_d;
  logic [N-1:0][COEFF_WIDTH-1:0]  reduced;
  logic                           in_xfer;
  logic                           out_xfer;

  // x^N == -1, so the upper columns fold back with a negative sign.
  always_comb begin
    reduced = '0;
    for (int k = 0; k < N - 1; k++) begin
      reduced[k] = in_cols[k] - in_cols[k+N];
    end
    reduced[N-1] = in_cols[N-1];
  end

  always_comb begin
    out_valid = (state_q == StEmit);
    out_last  = out_valid && (idx_q == IdxW'(N - 1));
    out_index = idx_q;
    out_coeff = coeff_q[idx_q];
    in_ready  = (state_q == StIdle) || (out_last && out_ready);
    in_xfer   = in_valid && in_ready;
    out_xfer  = out_valid && out_ready;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    coeff_d = coeff_q;
    if (in_xfer) begin
      // Also covers the zero-bubble handoff on the out_last beat.
      coeff_d = reduced;
      state_d = StEmit;
      idx_d   = '0;
    end else if (out_xfer) begin
      if (out_last) begin
        state_d = StIdle;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      coeff_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      coeff_q <= coeff_d;
    end
  end

endmodule

// File: tb/tb_negacyclic_reducer.sv
// Directed bench for negacyclic_reducer at N=4, COEFF_WIDTH=8.
module tb_negacyclic_reducer;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 8;

  logic                         clk;
  logic                         nrst;
  logic                         in_valid;
  logic                         in_ready;
  logic [2*N-2:0][CW-1:0]       in_cols;
  logic                         out_valid;
  logic                         out_ready;
  logic [CW-1:0]                out_coeff;
  logic [1:0]                   out_index;
  logic                         out_last;

  int tests;
  int fails;

  logic [2*N-2:0][CW-1:0] cols_basic;
  logic [2*N-2:0][CW-1:0] cols_wrap;
  logic [CW-1:0] exp_basic [4];
  logic [CW-1:0] exp_wrap  [4];

  negacyclic_reducer #(
    .N           (N),
    .COEFF_WIDTH (CW)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cols   (in_cols),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coeff (out_coeff),
    .out_index (out_index),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one polynomial at the current negedge and hold it across one posedge.
  task automatic load(input logic [2*N-2:0][CW-1:0] c);
    in_valid = 1'b1;
    in_cols  = c;
    @(negedge clk);
    in_valid = 1'b0;
    in_cols  = '0;
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_coeff !== 8'h00 ||
        out_index !== 2'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset: valid=%b last=%b coeff=%h idx=%0d rdy=%b, want 0 0 00 0 1",
               out_valid, out_last, out_coeff, out_index, in_ready);
    end
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_in_ready: got %b want 1", in_ready);
    end
    load(cols_basic);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_index !== 2'(i) || out_coeff !== exp_basic[i] ||
          out_last !== (i == 3)) begin
        fails++;
        $display("FAIL basic[%0d]: valid=%b idx=%0d coeff=%h last=%b, want 1 %0d %h %b",
                 i, out_valid, out_index, out_coeff, out_last, i, exp_basic[i], (i == 3));
      end
      @(negedge clk);
    end
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_idle: valid=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_wrap;
    out_ready = 1'b1;
    load(cols_wrap);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_index !== 2'(i) || out_coeff !== exp_wrap[i]) begin
        fails++;
        $display("FAIL wrap[%0d]: valid=%b idx=%0d coeff=%h, want 1 %0d %h",
                 i, out_valid, out_index, out_coeff, i, exp_wrap[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b1;
    load(cols_basic);
    @(negedge clk);
    @(negedge clk);
    // Stall at index 2 and offer a competing polynomial that must be ignored.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_cols   = cols_wrap;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (out_valid !== 1'b1 || out_index !== 2'd2 || out_coeff !== 8'hFC ||
          in_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall[%0d]: valid=%b idx=%0d coeff=%h rdy=%b, want 1 2 fc 0",
                 i, out_valid, out_index, out_coeff, in_ready);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_cols   = '0;
    out_ready = 1'b1;
    for (int i = 2; i < 4; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_index !== 2'(i) || out_coeff !== exp_basic[i]) begin
        fails++;
        $display("FAIL resume[%0d]: valid=%b idx=%0d coeff=%h, want 1 %0d %h",
                 i, out_valid, out_index, out_coeff, i, exp_basic[i]);
      end
      @(negedge clk);
    end
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL resume_end: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [CW-1:0] exp;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_cols   = cols_basic;
    @(negedge clk);
    in_cols = cols_wrap;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) in_valid = 1'b0;
      #1;
      exp = (k < 4) ? exp_basic[k] : exp_wrap[k-4];
      tests++;
      if (out_valid !== 1'b1 || out_index !== 2'(k % 4) || out_coeff !== exp ||
          out_last !== (k % 4 == 3)) begin
        fails++;
        $display("FAIL b2b[%0d]: valid=%b idx=%0d coeff=%h last=%b, want 1 %0d %h %b",
                 k, out_valid, out_index, out_coeff, out_last, k % 4, exp, (k % 4 == 3));
      end
      if (k < 4) begin
        tests++;
        if (in_ready !== (k == 3)) begin
          fails++;
          $display("FAIL b2b_rdy[%0d]: got %b want %b", k, in_ready, (k == 3));
        end
      end
      @(negedge clk);
    end
    in_cols = '0;
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_end: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_emit;
    out_ready = 1'b1;
    load(cols_basic);
    @(negedge clk);
    tests++;
    if (out_index !== 2'd1) begin
      fails++;
      $display("FAIL rst_pre: idx=%0d want 1", out_index);
    end
    nrst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_coeff !== 8'h00 || out_last !== 1'b0 ||
        in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_async: valid=%b coeff=%h last=%b rdy=%b, want 0 00 0 1",
               out_valid, out_coeff, out_last, in_ready);
    end
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_release: valid=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    load(cols_wrap);
    tests++;
    if (out_valid !== 1'b1 || out_index !== 2'd0 || out_coeff !== 8'hFF) begin
      fails++;
      $display("FAIL rst_restart: valid=%b idx=%0d coeff=%h, want 1 0 ff",
               out_valid, out_index, out_coeff);
    end
    for (int i = 0; i < 4; i++) @(negedge clk);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_cols   = '0;
    nrst      = 1'b1;

    for (int i = 0; i < 2 * N - 1; i++) cols_basic[i] = CW'(i + 1);
    cols_wrap    = '0;
    cols_wrap[4] = 8'h01;
    cols_wrap[1] = 8'h80;
    cols_wrap[5] = 8'h80;
    exp_basic = '{8'hFC, 8'hFC, 8'hFC, 8'h04};
    exp_wrap  = '{8'hFF, 8'h00, 8'h00, 8'h00};

    @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_emit();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/negacyclic_reducer.md
NEGACYCLIC_REDUCER -- requirements
Module: negacyclic_reducer

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning polynomial length (number of output coefficients, power of two, >= 2).
REQ-002 The block SHALL have parameter COEFF_WIDTH, default 8, meaning coefficient width in bits (arithmetic mod 2^COEFF_WIDTH).
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port nrst  input  1  meaning reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid  input  1  meaning the full product-column vector is present.
REQ-006 The block SHALL have port in_ready  output  1  meaning the block will accept in_cols this cycle.
REQ-007 The block SHALL have port in_cols  input  [2N-2:0][COEFF_WIDTH-1:0]  meaning linear-convolution column sums c0..c(2N-2), packed index = column index.
REQ-008 The block SHALL have port out_valid  output  1  meaning out_coeff is valid.
REQ-009 The block SHALL have port out_ready  input  1  meaning the consumer accepts out_coeff this cycle.
REQ-010 The block SHALL have port out_coeff  output  COEFF_WIDTH  meaning reduced coefficient r[out_index].
REQ-011 The block SHALL have port out_index  output  $clog2(N)  meaning index of out_coeff.
REQ-012 The block SHALL have port out_last  output  1  meaning out_coeff is r[N-1].

Function
REQ-013 Input transfer SHALL occur on a cycle with in_valid && in_ready; output transfer SHALL occur on a cycle with out_valid && out_ready.
REQ-014 On input transfer, the block SHALL register r[k] = (c[k] - c[k+N]) mod 2^COEFF_WIDTH for k = 0..N-2, and r[N-1] = c[N-1].
REQ-015 The FSM SHALL have two states: IDLE (no data held) and EMIT (reduced polynomial held).
REQ-016 IDLE -> EMIT SHALL occur on input transfer; EMIT -> IDLE SHALL occur on output transfer of out_last with no simultaneous input transfer; otherwise the FSM SHALL stay in EMIT.
REQ-017 in_ready SHALL equal (state == IDLE) || (state == EMIT && out_last && out_ready), combinationally.
REQ-018 out_valid SHALL equal (state == EMIT); out_coeff SHALL equal r[out_index]; out_last SHALL equal (state == EMIT && out_index == N-1).
REQ-019 Latency SHALL be one cycle: input transfer at edge t gives out_valid=1, out_index=0 after edge t.
REQ-020 out_index SHALL increment by 1 on each output transfer, and SHALL return to 0 after the out_last transfer.
REQ-021 With out_ready low, out_coeff, out_index and out_valid SHALL hold unchanged.
REQ-022 When the out_last transfer and an input transfer happen in the same cycle, the new polynomial SHALL be captured, the state SHALL stay EMIT and out_index SHALL be 0 on the next cycle (zero bubble).
REQ-023 in_cols SHALL be ignored when in_ready is low; in_valid asserted while busy SHALL NOT corrupt held data.

Reset
REQ-024 While nrst is low, state SHALL be IDLE, out_index 0, and the coefficient registers 0, so out_valid=0, out_last=0, out_coeff=0 and in_ready=1.
REQ-025 Reset asserted mid-EMIT SHALL discard the held polynomial immediately (asynchronously), with no partial emission after release.

Structure
REQ-026 The shared package he_poly_pkg SHALL hold the FSM state enum (IDLE, EMIT) and a coefficient typedef parameterised by COEFF_WIDTH.
REQ-027 The block SHALL be flat with no sub-module; N-1 subtractors SHALL sit combinationally before the capture registers.

Verification (N=4, COEFF_WIDTH=8)
REQ-028 Basic: in_cols c0..c6 = 1,2,3,4,5,6,7, out_ready=1 -> outputs 0xFC,0xFC,0xFC,0x04 on 4 consecutive cycles, indices 0..3, out_last on the 4th only.
REQ-029 Wrap: c0=0x00, c4=0x01, c1=0x80, c5=0x80, others 0 -> r0=0xFF, r1=0x00, r2=0x00, r3=0x00.
REQ-030 Backpressure: out_ready low for 3 cycles while out_index=2 -> out_coeff and out_index hold, in_ready stays 0, sequence resumes at index 2.
REQ-031 Back-to-back: in_valid held with two polynomials -> second accepted on the out_last cycle of the first, 8 outputs on 8 consecutive cycles.
REQ-032 Reset mid-emit: nrst low at out_index=1 -> out_valid=0 immediately; after release in_ready=1 and the next input restarts at index 0.
